tx_stream_fifo: RTL and testbench
=================================

// Module: tx_stream_fifo
// PURPOSE
//  Parametrised successor of the 3-bit tx handshake FSM: buffers up to DEPTH words
//  strobed in on tx and drains them over a valid/ready interface. Adds width/depth
//  parameters, a pause input, a synchronous flush, and full/empty/count/overflow status.
//  Sits between a producer that pulses tx and any ready-driven sink.
// PARAMETERS
//  WIDTH  8  payload width in bits (>=1)
//  DEPTH  4  buffer entries; power of two, >=2; pointers wrap modulo DEPTH
// PORTS
//  clk         in   1                    single clock, rising edge
//  reset       in   1                    asynchronous, active-high reset
//  data        in   WIDTH                write payload, sampled when tx=1
//  tx          in   1                    write strobe, one word per cycle
//  en_i        in   1                    1 = drain allowed; 0 = pause after current beat
//  clr_i       in   1                    synchronous flush; priority over tx/ready
//  ready_i     in   1                    sink ready
//  valid_o     out  1                    head word valid (registered)
//  data_o      out  WIDTH(+1, see CONFIG) head word, from storage regs only
//  count_o     out  $clog2(DEPTH+1)      occupancy
//  full_o      out  1                    count_o==DEPTH
//  empty_o     out  1                    count_o==0
//  overflow_o  out  1                    sticky: write dropped while full
// BEHAVIOUR
//  Reset (async, reset=1): state=IDLE, ptrs=0, count_o=0, valid_o=0, data_o=0,
//   empty_o=1, full_o=0, overflow_o=0. Storage contents need not be cleared.
//  Push = tx & (~full_o | pop). Pop = valid_o & ready_i. Beat transfers on pop.
//  tx while full with no pop in same cycle: word dropped, overflow_o<=1.
//  Full with pop and tx in same cycle: both happen, count unchanged.
//  count_o next = count + push - pop; never exceeds DEPTH, never underflows.
//  FSM states: IDLE, SEND, HOLD.
//   IDLE: valid_o=0. -> SEND if en_i & (count>0 after this cycle's push).
//         -> HOLD if ~en_i & data present.
//   SEND: valid_o=1, data_o=head. Stay while words remain after pop.
//         -> IDLE when last word pops and no push this cycle.
//         -> HOLD when en_i=0 and no beat is outstanding or on pop.
//         valid_o never drops, and data_o never changes, until pop occurs.
//   HOLD: valid_o=0, buffer keeps accepting pushes. -> SEND when en_i=1 & count>0;
//         -> IDLE when en_i=1 & count==0.
//  Latency: tx into empty buffer at edge N gives valid_o=1 after edge N+1 (1 cycle).
//   Back-to-back pops with ready_i held high sustain 1 word/cycle.
//  clr_i=1: ptrs=0, count=0, valid_o=0, state=IDLE, overflow_o=0 at next edge.
//   Concurrent tx is ignored. In-flight beat is discarded, not counted as transferred.
//  Reset mid-burst: all state is abandoned immediately. valid_o falls asynchronously.
// CONFIGURATION
//  TX_PARITY_EN defined: data_o is WIDTH+1 bits; the MSB is even parity (XOR) of
//   the payload, computed at push and stored with the word; the reset value is 0.
//  TX_PARITY_EN undefined: data_o is exactly WIDTH bits; no parity logic.
// TESTING (WIDTH=8, DEPTH=4)
//  1 reset=1 mid-stream -> valid_o=0, count_o=0, empty_o=1, overflow_o=0 at once.
//  2 Push 0xA5 with ready_i=0 and en_i=1 -> next cycle valid_o=1 and data_o=0xA5.
//    Hold 5 cycles -> outputs stable. Then ready_i=1 -> 1 pop, empty_o=1,
//    valid_o=0 next cycle.
//  3 Push 0x01..0x05 on consecutive cycles with ready_i=0 -> full_o=1 after 4,
//    overflow_o=1, count_o=4. Drain -> 0x01,0x02,0x03,0x04 in order.
//  4 Full buffer with tx=1 and ready_i=1 in the same cycle -> count_o stays 4,
//    no overflow, new word lands last.
//  5 en_i=0 during SEND with ready_i=0 -> 0x10 stays valid until it pops, then HOLD.
//    Push 0x11 -> valid_o=0. en_i=1 -> 0x11 presented next cycle.
//  6 clr_i=1 with count_o=3 and tx=1 -> count_o=0, valid_o=0, overflow_o=0.
//    With TX_PARITY_EN, push 0x07 -> data_o=9'h107.

Source files
------------

// File: rtl/tx_stream_fifo.sv
// tx_stream_fifo: buffers words strobed in on tx and drains them to a sink
// over a valid/ready interface. It supports a pause input (en_i), a
// synchronous flush (clr_i) and occupancy/overflow status outputs.
// Optional feature macro: TX_PARITY_EN. When it is defined, data_o is
// WIDTH+1 bits and its MSB is the XOR parity of the payload, computed at push.
//
// Handshake: the sink sees a word on data_o while valid_o=1. A beat transfers
// on a rising edge where valid_o=1 and ready_i=1. Once valid_o rises, valid_o
// and data_o stay unchanged until that beat transfers. The exceptions are
// clr_i and reset, which discard the beat.
module tx_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data,
  input  logic                       tx,
  input  logic                       en_i,
  input  logic                       clr_i,
  input  logic                       ready_i,
  output logic                       valid_o,
`ifdef TX_PARITY_EN
  output logic [WIDTH:0]             data_o,
`else
  output logic [WIDTH-1:0]           data_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o
);

`ifdef TX_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // SEND is the only state that presents a beat, so valid_o == (state == SEND).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Kept as a named internal signal so that checkers can bind to it.
  state_t state;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] cnt_after_pop;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] in_word;
  logic [DW-1:0] head_nxt;
  logic          push;
  logic          pop;
  logic          drop;

`ifdef TX_PARITY_EN
  assign in_word = {^data, data};
`else
  assign in_word = data;
`endif

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);

  // Transfer qualification, occupancy arithmetic and the next head word.
  // The next head word bypasses storage when the buffer would otherwise be
  // empty and a word is being pushed in the same cycle.
  always_comb begin
    pop           = valid_o & ready_i & ~clr_i;
    push          = tx & (~full_o | pop) & ~clr_i;
    drop          = tx & full_o & ~pop & ~clr_i;
    rd_ptr_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
    cnt_after_pop = count_o - CW'(pop);
    cnt_nxt       = cnt_after_pop + CW'(push);
    head_nxt      = (push && (cnt_after_pop == '0)) ? in_word : mem[rd_ptr_nxt];
  end

  // Storage write. Contents are never reset; they are only read when occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_word;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      count_o <= cnt_nxt;
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Drain FSM with registered valid_o/data_o. data_o reloads only when a new
  // beat starts, so it cannot change while a beat is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (clr_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt_nxt != '0) begin
            if (en_i) begin
              state   <= SEND;
              valid_o <= 1'b1;
              data_o  <= head_nxt;
            end else begin
              state <= HOLD;
            end
          end
        end
        SEND: begin
          if (pop) begin
            if (!en_i) begin
              state   <= HOLD;
              valid_o <= 1'b0;
            end else if (cnt_nxt == '0) begin
              state   <= IDLE;
              valid_o <= 1'b0;
            end else begin
              data_o <= head_nxt;
            end
          end
        end
        HOLD: begin
          if (en_i) begin
            if (cnt_nxt != '0) begin
              state   <= SEND;
              valid_o <= 1'b1;
              data_o  <= head_nxt;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_stream_fifo.sv
// Directed bench for tx_stream_fifo (WIDTH=8, DEPTH=4). The driver pushes each
// word the sink should eventually receive into exp_q. A negedge monitor pops
// and compares on every transferring beat.
module tb_tx_stream_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef TX_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data;
  logic             tx;
  logic             en_i;
  logic             clr_i;
  logic             ready_i;
  logic             valid_o;
  logic [DW-1:0]    data_o;
  logic [2:0]       count_o;
  logic             full_o;
  logic             empty_o;
  logic             overflow_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  tx_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .tx         (tx),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] word_of(input logic [WIDTH-1:0] b);
`ifdef TX_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] b, input bit accept);
    data = b;
    tx   = 1'b1;
    if (accept) exp_q.push_back(word_of(b));
    step();
    tx = 1'b0;
  endtask

  // scoreboard monitor: a beat transfers at the coming edge
  always @(negedge clk) begin
    if (reset === 1'b0 && clr_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got 0x%0h expected no beat at %0t", data_o, $time);
      end else begin
        check("beat_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; data = '0; tx = 1'b0; en_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_overflow", 32'(overflow_o), 0);
    check("rst_data", 32'(data_o), 0);
    reset = 1'b0;
    step();

    // single word, sink stalled for 5 cycles, then one pop
    en_i = 1'b1;
    push_word(8'hA5, 1'b1);
    check("t2_valid", 32'(valid_o), 1);
    check("t2_data", 32'(data_o), 32'(word_of(8'hA5)));
    check("t2_count", 32'(count_o), 1);
    check("t2_empty", 32'(empty_o), 0);
    repeat (5) begin
      step();
      check("t2_hold_valid", 32'(valid_o), 1);
      check("t2_hold_data", 32'(data_o), 32'(word_of(8'hA5)));
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("t2_after_valid", 32'(valid_o), 0);
    check("t2_after_empty", 32'(empty_o), 1);
    check("t2_after_count", 32'(count_o), 0);

    // overfill by one word, then drain at 1 word/cycle
    for (int i = 1; i <= 5; i++) begin
      push_word(8'(i), i <= 4);
      if (i == 4) check("t3_full_at4", 32'(full_o), 1);
    end
    check("t3_full", 32'(full_o), 1);
    check("t3_count", 32'(count_o), 4);
    check("t3_overflow", 32'(overflow_o), 1);
    check("t3_head", 32'(data_o), 32'(word_of(8'h01)));
    ready_i = 1'b1;
    repeat (4) step();
    ready_i = 1'b0;
    check("t3_drain_empty", 32'(empty_o), 1);
    check("t3_drain_valid", 32'(valid_o), 0);
    check("t3_sticky_overflow", 32'(overflow_o), 1);

    // flush clears the sticky overflow
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_overflow", 32'(overflow_o), 0);

    // full buffer with push and pop in the same cycle
    for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i), 1'b1);
    check("t4_full", 32'(full_o), 1);
    ready_i = 1'b1;
    data    = 8'h24;
    tx      = 1'b1;
    exp_q.push_back(word_of(8'h24));
    step();
    tx      = 1'b0;
    ready_i = 1'b0;
    check("t4_count", 32'(count_o), 4);
    check("t4_full_kept", 32'(full_o), 1);
    check("t4_no_overflow", 32'(overflow_o), 0);
    check("t4_head", 32'(data_o), 32'(word_of(8'h21)));
    ready_i = 1'b1;
    repeat (4) step();
    ready_i = 1'b0;
    check("t4_empty", 32'(empty_o), 1);

    // pause during an outstanding beat
    push_word(8'h10, 1'b1);
    check("t5_valid", 32'(valid_o), 1);
    en_i = 1'b0;
    repeat (2) begin
      step();
      check("t5_paused_valid", 32'(valid_o), 1);
      check("t5_paused_data", 32'(data_o), 32'(word_of(8'h10)));
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("t5_hold_valid", 32'(valid_o), 0);
    push_word(8'h11, 1'b1);
    check("t5_hold_push_valid", 32'(valid_o), 0);
    check("t5_hold_push_count", 32'(count_o), 1);
    step();
    check("t5_hold_still", 32'(valid_o), 0);
    en_i = 1'b1;
    step();
    check("t5_resume_valid", 32'(valid_o), 1);
    check("t5_resume_data", 32'(data_o), 32'(word_of(8'h11)));
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("t5_empty", 32'(empty_o), 1);

    // flush with a concurrent tx
    for (int i = 0; i < 3; i++) push_word(8'h30 + 8'(i), 1'b1);
    check("t6_count3", 32'(count_o), 3);
    clr_i = 1'b1;
    tx    = 1'b1;
    data  = 8'h33;
    exp_q.delete();
    step();
    clr_i = 1'b0;
    tx    = 1'b0;
    check("t6_count", 32'(count_o), 0);
    check("t6_valid", 32'(valid_o), 0);
    check("t6_empty", 32'(empty_o), 1);
    check("t6_overflow", 32'(overflow_o), 0);
    step();
    check("t6_tx_ignored", 32'(count_o), 0);
    push_word(8'h07, 1'b1);
    check("t6_valid7", 32'(valid_o), 1);
`ifdef TX_PARITY_EN
    check("t6_data7", 32'(data_o), 32'h107);
`else
    check("t6_data7", 32'(data_o), 32'h07);
`endif
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i), i < 4);
    check("t1_pre_overflow", 32'(overflow_o), 1);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t1_valid", 32'(valid_o), 0);
    check("t1_count", 32'(count_o), 0);
    check("t1_empty", 32'(empty_o), 1);
    check("t1_full", 32'(full_o), 0);
    check("t1_overflow", 32'(overflow_o), 0);
    step();
    reset = 1'b0;
    step();
    check("t1_idle_valid", 32'(valid_o), 0);
    push_word(8'h5C, 1'b1);
    check("t1_recover_data", 32'(data_o), 32'(word_of(8'h5C)));
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    step();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
